vram_loader: RTL and testbench

- Writer for the 8 KB screen memory that the video block reads. The video block fetches pixel/attribute bytes through a[12:0]/d[7:0]; this block fills the same memory from a byte stream.
- Accepts framed byte-stream commands from a host link (UART/SPI front end): load a full 6912-byte screen, or set the border colour.
- Drives a single write port into the VRAM's write side and the 3-bit border register consumed by the video block.

---
 rtl/zx_pkg.sv | 18 +
 rtl/vram_loader_frame_timer.sv | 32 +++
 rtl/vram_loader.sv | 152 +++++++++++++++
 tb/tb_vram_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/zx_pkg.sv
// Shared constants and state encoding for the screen loader.
package zx_pkg;

    localparam int          SCR_SIZE   = 6912;
    localparam int          SCR_AW     = 13;
    localparam logic [7:0]  CMD_LOAD   = 8'h01;
    localparam logic [7:0]  CMD_BORDER = 8'h02;
    localparam logic [7:0]  FRAME_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LOAD,
        SUM,
        BORD
    } state_e;

endpackage

// File: rtl/vram_loader_frame_timer.sv
// Loadable down-counter that flags a frame stalled for TIMEOUT consecutive cycles.
module frame_timer #(
    parameter int unsigned TIMEOUT = 1400000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= TW'(TIMEOUT);
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i)
            cnt_d = TW'(TIMEOUT);
        else if (run_i && cnt_q != '0)
            cnt_d = cnt_q - TW'(1);
    end

    // Fires on the TIMEOUT-th idle cycle since the last restart.
    assign expire_o = run_i && !restart_i && (cnt_q == TW'(1));

endmodule

// File: rtl/vram_loader.sv
// Framed byte-stream writer for screen memory: full screen load with XOR checksum,
// or border colour set.
module vram_loader
    import zx_pkg::*;
#(
    parameter int          SIZE    = SCR_SIZE,
    parameter int          AW      = SCR_AW,
    parameter logic [7:0]  SYNC    = FRAME_SYNC,
    parameter int unsigned TIMEOUT = 1400000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sValid,
    input  logic [7:0]    sData,
    output logic          sReady,
    output logic          we,
    output logic [AW-1:0] a,
    output logic [7:0]    d,
    output logic [2:0]    border,
    output logic          busy,
    output logic          done,
    output logic          error
);

    state_e        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [7:0]    chk_q, chk_d;
    logic          we_q, we_d;
    logic [AW-1:0] a_q, a_d;
    logic [7:0]    d_q, d_d;
    logic [2:0]    border_q, border_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          ready_q;
    logic          accept;
    logic          expire;

    assign accept = sValid && ready_q;

    frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .restart_i (accept || state_q == IDLE),
        .run_i     (state_q != IDLE),
        .expire_o  (expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            chk_q    <= '0;
            we_q     <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
            border_q <= 3'd7;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            chk_q    <= chk_d;
            we_q     <= we_d;
            a_q      <= a_d;
            d_q      <= d_d;
            border_q <= border_d;
            done_q   <= done_d;
            error_q  <= error_d;
            ready_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        chk_d    = chk_q;
        we_d     = 1'b0;
        a_d      = a_q;
        d_d      = d_q;
        border_d = border_q;
        done_d   = 1'b0;
        error_d  = error_q;

        unique case (state_q)
            IDLE: begin
                if (accept && sData == SYNC) begin
                    state_d = CMD;
                    error_d = 1'b0;
                end
            end
            CMD: begin
                if (accept) begin
                    if (sData == CMD_LOAD) begin
                        state_d = LOAD;
                        count_d = '0;
                        chk_d   = '0;
                    end else if (sData == CMD_BORDER) begin
                        state_d = BORD;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Any byte here is payload, including one equal to SYNC.
                if (accept) begin
                    we_d    = 1'b1;
                    a_d     = count_q;
                    d_d     = sData;
                    chk_d   = chk_q ^ sData;
                    count_d = count_q + AW'(1);
                    if (count_q == AW'(SIZE - 1))
                        state_d = SUM;
                end
            end
            SUM: begin
                if (accept) begin
                    state_d = IDLE;
                    if (sData == chk_q) done_d  = 1'b1;
                    else                error_d = 1'b1;
                end
            end
            BORD: begin
                if (accept) begin
                    border_d = sData[2:0];
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (expire) begin
            state_d = IDLE;
            error_d = 1'b1;
            we_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign sReady = ready_q;
    assign we     = we_q;
    assign a      = a_q;
    assign d      = d_q;
    assign border = border_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: tb/tb_vram_loader.sv
// Directed bench for vram_loader; a negedge monitor tallies VRAM writes and done pulses.
module tb_vram_loader;

    localparam int SIZE = 6912;
    localparam int TMO  = 300;

    logic        clock = 1'b0;
    logic        reset;
    logic        sValid;
    logic [7:0]  sData;
    logic        sReady;
    logic        we;
    logic [12:0] a;
    logic [7:0]  d;
    logic [2:0]  border;
    logic        busy;
    logic        done;
    logic        error;

    int vecCount  = 0;
    int missCount = 0;

    int          totalWrites = 0;
    int          seqErr      = 0;
    int          dataErr     = 0;
    int          rangeErr    = 0;
    int          doneCount   = 0;
    int          doneBusyErr = 0;
    int          doneErrErr  = 0;
    logic [12:0] prevA       = '0;

    int w0, d0;

    vram_loader #(.TIMEOUT(TMO)) dut (
        .clock  (clock),
        .reset  (reset),
        .sValid (sValid),
        .sData  (sData),
        .sReady (sReady),
        .we     (we),
        .a      (a),
        .d      (d),
        .border (border),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    always #5 clock = ~clock;

    // Payload byte i is always i & 8'hFF, so data must equal the low address byte.
    always @(negedge clock) begin
        if (we === 1'b1) begin
            totalWrites++;
            if (!(a == 13'd0 || a == prevA + 13'd1)) seqErr++;
            if (d !== a[7:0]) dataErr++;
            if (a >= 13'(SIZE)) rangeErr++;
            prevA = a;
        end
        if (done === 1'b1) begin
            doneCount++;
            if (busy !== 1'b0)  doneBusyErr++;
            if (error !== 1'b0) doneErrErr++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        sValid = 1'b1;
        sData  = b;
        @(posedge clock);
        #1;
        sValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
        end
    endtask

    task automatic sendLoad(input int nBytes, input logic [7:0] sum, input bit withSum, input bit gaps);
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        for (int i = 0; i < nBytes; i++) begin
            if (gaps) idleCycles(int'($urandom_range(0, 3)));
            applyStimulus(8'(i));
        end
        if (withSum) applyStimulus(sum);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        sValid = 1'b0;
        sData  = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("readyInReset", 32'(sReady), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idleCycles(2);
        checkOutput("readyAfterReset", 32'(sReady), 32'd1);
        checkOutput("borderReset", 32'(border), 32'd7);
        checkOutput("busyReset", 32'(busy), 32'd0);
        checkOutput("errorReset", 32'(error), 32'd0);
        checkOutput("doneReset", 32'(done), 32'd0);

        // Border set: only the low three bits of FA are kept.
        w0 = totalWrites; d0 = doneCount;
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'hFA);
        idleCycles(2);
        checkOutput("borderSet", 32'(border), 32'd2);
        checkOutput("borderDone", 32'(doneCount - d0), 32'd1);
        checkOutput("borderError", 32'(error), 32'd0);
        checkOutput("borderWrites", 32'(totalWrites - w0), 32'd0);

        // Good load: XOR of 27 full 0..255 ramps is 0.
        w0 = totalWrites; d0 = doneCount;
        sendLoad(SIZE, 8'h00, 1'b1, 1'b0);
        checkOutput("doneAtSum", 32'(done), 32'd1);
        checkOutput("busyAtSum", 32'(busy), 32'd0);
        idleCycles(2);
        checkOutput("loadWrites", 32'(totalWrites - w0), 32'(SIZE));
        checkOutput("loadLastAddr", 32'(prevA), 32'(SIZE - 1));
        checkOutput("loadSeq", 32'(seqErr), 32'd0);
        checkOutput("loadData", 32'(dataErr), 32'd0);
        checkOutput("loadDone", 32'(doneCount - d0), 32'd1);
        checkOutput("loadError", 32'(error), 32'd0);
        checkOutput("doneBusyOverlap", 32'(doneBusyErr), 32'd0);

        w0 = totalWrites; d0 = doneCount;
        sendLoad(SIZE, 8'h55, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("badSumWrites", 32'(totalWrites - w0), 32'(SIZE));
        checkOutput("badSumError", 32'(error), 32'd1);
        checkOutput("badSumDone", 32'(doneCount - d0), 32'd0);
        checkOutput("badSumBusy", 32'(busy), 32'd0);

        w0 = totalWrites;
        applyStimulus(8'hA5);
        checkOutput("syncClearsError", 32'(error), 32'd0);
        checkOutput("busyInCmd", 32'(busy), 32'd1);
        applyStimulus(8'h07);
        idleCycles(2);
        checkOutput("badCmdError", 32'(error), 32'd1);
        checkOutput("badCmdBusy", 32'(busy), 32'd0);
        checkOutput("badCmdWrites", 32'(totalWrites - w0), 32'd0);

        d0 = doneCount;
        applyStimulus(8'hA5);
        checkOutput("syncClearsError2", 32'(error), 32'd0);
        applyStimulus(8'h02); applyStimulus(8'h03);
        idleCycles(2);
        checkOutput("border3", 32'(border), 32'd3);
        checkOutput("border3Done", 32'(doneCount - d0), 32'd1);

        // Stall mid-load: still busy just short of the limit, aborted just past it.
        w0 = totalWrites;
        sendLoad(100, 8'h00, 1'b0, 1'b0);
        idleCycles(TMO - 10);
        checkOutput("preTimeoutBusy", 32'(busy), 32'd1);
        checkOutput("preTimeoutError", 32'(error), 32'd0);
        idleCycles(20);
        checkOutput("timeoutError", 32'(error), 32'd1);
        checkOutput("timeoutBusy", 32'(busy), 32'd0);
        checkOutput("timeoutWrites", 32'(totalWrites - w0), 32'd100);

        sendLoad(50, 8'h00, 1'b0, 1'b0);
        sValid = 1'b1;
        sData  = 8'h33;
        reset  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        w0 = totalWrites;
        checkOutput("rstReady", 32'(sReady), 32'd0);
        checkOutput("rstWe", 32'(we), 32'd0);
        checkOutput("rstA", 32'(a), 32'd0);
        checkOutput("rstD", 32'(d), 32'd0);
        checkOutput("rstBorder", 32'(border), 32'd7);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstError", 32'(error), 32'd0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        sValid = 1'b0;
        idleCycles(20);
        checkOutput("writesAfterReset", 32'(totalWrites - w0), 32'd0);
        checkOutput("idleAfterReset", 32'(busy), 32'd0);

        // Stray bytes, then a load with random gaps well below the timeout.
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        w0 = totalWrites; d0 = doneCount;
        sendLoad(SIZE, 8'h00, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("gapWrites", 32'(totalWrites - w0), 32'(SIZE));
        checkOutput("gapLastAddr", 32'(prevA), 32'(SIZE - 1));
        checkOutput("gapDone", 32'(doneCount - d0), 32'd1);
        checkOutput("gapError", 32'(error), 32'd0);
        checkOutput("gapSeq", 32'(seqErr), 32'd0);
        checkOutput("gapData", 32'(dataErr), 32'd0);
        checkOutput("addrRange", 32'(rangeErr), 32'd0);
        checkOutput("doneWithError", 32'(doneErrErr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
